closest_hit_select: RTL and testbench

- Reduces a stream of per-object ray-intersection results (one beat per object, NUM_OBJS beats per ray) to a single nearest valid hit per pixel.
- Sits between the per-object intersect stage (sphere plus cylinders, time-multiplexed) and hit-point/shading.
- Generalises the single-object undef masking to N objects, with minimum-t selection, a near-plane threshold and pixel-coordinate sideband.

---
 rtl/closest_hit_select.sv | 158 +++++++++++++++
 tb/tb_closest_hit_select.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/closest_hit_select.sv
// closest_hit_select
// -----------------------------------------------------------------------------
// Reduces a stream of per-object ray-intersection results to one nearest valid
// hit per pixel. Each ray arrives as NUM_OBJS beats, one per object. Beat k
// carries object k. The block keeps the smallest t that counts as a hit and
// emits it, with the object index and the pixel coordinates taken from beat 0,
// one cycle after the last beat of the ray is accepted.
//
// A beat counts as a hit when all of these hold:
//   - undef is clear
//   - t is a positive, finite float
//   - t is strictly greater than MIN_T
// Positive IEEE-754 singles order the same way as their integer magnitudes, so
// every comparison is an unsigned compare on t[30:0].
//
// Ports
//   aclk, areset            clock, asynchronous active-high reset
//   s_axis_t_tdata          intersection distance t for the current object
//   s_axis_undef_tdata      1 = this object was not intersected
//   s_axis_hcount_tdata     pixel hcount (used from beat 0 only)
//   s_axis_vcount_tdata     pixel vcount (used from beat 0 only)
//   s_axis_tvalid/tready    input beat handshake
//   m_axis_t_tdata          nearest valid t (0 when there is no hit)
//   m_axis_obj_tdata        index of the nearest object (0 when there is no hit)
//   m_axis_hit_tdata        1 = at least one valid hit
//   m_axis_hcount_tdata     pixel hcount of this ray
//   m_axis_vcount_tdata     pixel vcount of this ray
//   m_axis_tvalid/tready    result handshake (single register stage)
// -----------------------------------------------------------------------------
module closest_hit_select #(
  parameter int              SIZE     = 32,
  parameter int              NUM_OBJS = 11,
  parameter int              IDX_W    = (NUM_OBJS > 1) ? $clog2(NUM_OBJS) : 1,
  parameter logic [SIZE-1:0] MIN_T    = 32'h3A83126F
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [SIZE-1:0]  s_axis_t_tdata,
  input  logic             s_axis_undef_tdata,
  input  logic [10:0]      s_axis_hcount_tdata,
  input  logic [9:0]       s_axis_vcount_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [SIZE-1:0]  m_axis_t_tdata,
  output logic [IDX_W-1:0] m_axis_obj_tdata,
  output logic             m_axis_hit_tdata,
  output logic [10:0]      m_axis_hcount_tdata,
  output logic [9:0]       m_axis_vcount_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJS - 1);
  localparam logic [30:0]      MIN_MAG  = MIN_T[30:0];

  // Beat counter and running minimum for the ray in progress
  logic [IDX_W-1:0] count;
  logic             acc_hit;
  logic [SIZE-1:0]  acc_t;
  logic [IDX_W-1:0] acc_idx;
  logic [10:0]      acc_hcount;
  logic [9:0]       acc_vcount;

  logic             beat_accept;
  logic             first_beat;
  logic             last_beat;
  logic             valid_hit;

  // Accumulator state once the current beat has been folded in
  logic             nxt_hit;
  logic [SIZE-1:0]  nxt_t;
  logic [IDX_W-1:0] nxt_idx;
  logic [10:0]      ray_hcount;
  logic [9:0]       ray_vcount;

  // A single stall rule applies to every beat. Input is taken whenever the
  // output register is empty or is being drained in this cycle.
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign beat_accept   = s_axis_tvalid & s_axis_tready;
  assign first_beat    = (count == '0);
  assign last_beat     = (count == LAST_IDX);

  // Sign, exponent and magnitude tests together reject negatives, Inf, NaN,
  // zero and anything at or below the near plane.
  assign valid_hit = ~s_axis_undef_tdata
                   & ~s_axis_t_tdata[31]
                   & (s_axis_t_tdata[30:23] != 8'hFF)
                   & (s_axis_t_tdata[30:0] > MIN_MAG);

  // When NUM_OBJS is 1, the first beat is also the last. The coordinates must
  // then bypass the accumulator.
  assign ray_hcount = first_beat ? s_axis_hcount_tdata : acc_hcount;
  assign ray_vcount = first_beat ? s_axis_vcount_tdata : acc_vcount;

  // NOTE: every output of this block is given a default before the branches.
  // A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    nxt_hit = acc_hit;
    nxt_t   = acc_t;
    nxt_idx = acc_idx;
    if (first_beat) begin
      nxt_hit = valid_hit;
      nxt_t   = valid_hit ? s_axis_t_tdata : '0;
      nxt_idx = '0;
    end else if (valid_hit && (!acc_hit || (s_axis_t_tdata[30:0] < acc_t[30:0]))) begin
      // A strictly-less compare keeps the lower index when two t values tie.
      nxt_hit = 1'b1;
      nxt_t   = s_axis_t_tdata;
      nxt_idx = count;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every process
  // then sees the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      count      <= '0;
      acc_hit    <= 1'b0;
      acc_t      <= '0;
      acc_idx    <= '0;
      acc_hcount <= '0;
      acc_vcount <= '0;
    end else if (beat_accept) begin
      count   <= last_beat ? '0 : count + IDX_W'(1);
      acc_hit <= nxt_hit;
      acc_t   <= nxt_t;
      acc_idx <= nxt_idx;
      if (first_beat) begin
        acc_hcount <= s_axis_hcount_tdata;
        acc_vcount <= s_axis_vcount_tdata;
      end
    end
  end

  // Output register. Loading a new result takes priority over clearing valid.
  // When the last beat arrives in the same cycle as a downstream handshake,
  // the new result replaces the old one with nothing lost or repeated.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_t_tdata      <= '0;
      m_axis_obj_tdata    <= '0;
      m_axis_hit_tdata    <= 1'b0;
      m_axis_hcount_tdata <= '0;
      m_axis_vcount_tdata <= '0;
      m_axis_tvalid       <= 1'b0;
    end else if (beat_accept && last_beat) begin
      m_axis_t_tdata      <= nxt_t;
      m_axis_obj_tdata    <= nxt_idx;
      m_axis_hit_tdata    <= nxt_hit;
      m_axis_hcount_tdata <= ray_hcount;
      m_axis_vcount_tdata <= ray_vcount;
      m_axis_tvalid       <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_closest_hit_select.sv
`timescale 1ns/1ps
// Bench for closest_hit_select.
// dut3 (NUM_OBJS=3) runs the directed vectors and the corner sequences.
// dut11 (NUM_OBJS=11) runs random rays with random valid and ready.
// For each DUT, expected results are queued as rays are driven and are popped
// when the DUT completes an output handshake.
module tb_closest_hit_select;

  localparam logic [30:0] MIN_MAG = 31'h3A83126F;

  typedef struct packed {
    logic [31:0] t;
    logic [3:0]  obj;
    logic        hit;
    logic [10:0] hc;
    logic [9:0]  vc;
  } res_t;

  typedef struct {
    string           name;
    logic [2:0][31:0] t;
    logic [2:0]      u;
    logic [10:0]     hc;
    logic [9:0]      vc;
    logic [31:0]     et;
    logic [1:0]      eo;
    logic            eh;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- dut3 signals ----------------
  logic        rst3 = 1'b1;
  logic [31:0] s_t3 = '0;
  logic        s_u3 = 1'b0;
  logic [10:0] s_hc3 = '0;
  logic [9:0]  s_vc3 = '0;
  logic        s_tvalid3 = 1'b0;
  logic        s_tready3;
  logic [31:0] m_t3;
  logic [1:0]  m_obj3;
  logic        m_hit3;
  logic [10:0] m_hc3;
  logic [9:0]  m_vc3;
  logic        m_tvalid3;
  logic        m_tready3 = 1'b1;

  // ---------------- dut11 signals ----------------
  logic        rst11 = 1'b1;
  logic [31:0] s_t11 = '0;
  logic        s_u11 = 1'b0;
  logic [10:0] s_hc11 = '0;
  logic [9:0]  s_vc11 = '0;
  logic        s_tvalid11 = 1'b0;
  logic        s_tready11;
  logic [31:0] m_t11;
  logic [3:0]  m_obj11;
  logic        m_hit11;
  logic [10:0] m_hc11;
  logic [9:0]  m_vc11;
  logic        m_tvalid11;
  logic        m_tready11 = 1'b1;

  res_t q3[$];
  res_t q11[$];

  closest_hit_select #(.NUM_OBJS(3)) dut3 (
    .aclk(clk), .areset(rst3),
    .s_axis_t_tdata(s_t3), .s_axis_undef_tdata(s_u3),
    .s_axis_hcount_tdata(s_hc3), .s_axis_vcount_tdata(s_vc3),
    .s_axis_tvalid(s_tvalid3), .s_axis_tready(s_tready3),
    .m_axis_t_tdata(m_t3), .m_axis_obj_tdata(m_obj3), .m_axis_hit_tdata(m_hit3),
    .m_axis_hcount_tdata(m_hc3), .m_axis_vcount_tdata(m_vc3),
    .m_axis_tvalid(m_tvalid3), .m_axis_tready(m_tready3)
  );

  closest_hit_select #(.NUM_OBJS(11)) dut11 (
    .aclk(clk), .areset(rst11),
    .s_axis_t_tdata(s_t11), .s_axis_undef_tdata(s_u11),
    .s_axis_hcount_tdata(s_hc11), .s_axis_vcount_tdata(s_vc11),
    .s_axis_tvalid(s_tvalid11), .s_axis_tready(s_tready11),
    .m_axis_t_tdata(m_t11), .m_axis_obj_tdata(m_obj11), .m_axis_hit_tdata(m_hit11),
    .m_axis_hcount_tdata(m_hc11), .m_axis_vcount_tdata(m_vc11),
    .m_axis_tvalid(m_tvalid11), .m_axis_tready(m_tready11)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_hit(input logic [31:0] t, input logic u);
    return !u && !t[31] && (t[30:23] != 8'hFF) && (t[30:0] > MIN_MAG);
  endfunction

  function automatic res_t model(input logic [10:0][31:0] t, input logic [10:0] u,
                                 input int n, input logic [10:0] hc, input logic [9:0] vc);
    res_t r;
    r = '{t: 32'h0, obj: 4'h0, hit: 1'b0, hc: hc, vc: vc};
    for (int i = 0; i < n; i++) begin
      if (is_hit(t[i], u[i]) && (!r.hit || t[i][30:0] < r.t[30:0])) begin
        r.hit = 1'b1;
        r.t   = t[i];
        r.obj = 4'(i);
      end
    end
    return r;
  endfunction

  // ---------------- monitors ----------------
  // m_tready changes only 2ns after a rising edge, so its value at the falling
  // edge is the one the next rising edge will see.
  always @(negedge clk) begin
    res_t got, exp;
    if (!rst3 && m_tvalid3 && m_tready3) begin
      got = '{t: m_t3, obj: {2'b00, m_obj3}, hit: m_hit3, hc: m_hc3, vc: m_vc3};
      if (q3.size() == 0) check("dut3_unexpected_result", 64'(got), 64'h0);
      else begin
        exp = q3.pop_front();
        check("dut3_result", 64'(got), 64'(exp));
      end
    end
  end

  always @(negedge clk) begin
    res_t got, exp;
    if (!rst11 && m_tvalid11 && m_tready11) begin
      got = '{t: m_t11, obj: m_obj11, hit: m_hit11, hc: m_hc11, vc: m_vc11};
      if (q11.size() == 0) check("dut11_unexpected_result", 64'(got), 64'h0);
      else begin
        exp = q11.pop_front();
        check("dut11_result", 64'(got), 64'(exp));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic beat3(input logic [31:0] t, input logic u, input logic [10:0] hc, input logic [9:0] vc);
    int n;
    @(negedge clk);
    s_tvalid3 = 1'b1; s_t3 = t; s_u3 = u; s_hc3 = hc; s_vc3 = vc;
    n = 0;
    while (!s_tready3 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("dut3_s_tready_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  // Later beats carry different coordinates, and the DUT must ignore them.
  task automatic ray3(input logic [2:0][31:0] t, input logic [2:0] u,
                      input logic [10:0] hc, input logic [9:0] vc);
    beat3(t[0], u[0], hc, vc);
    beat3(t[1], u[1], ~hc, ~vc);
    beat3(t[2], u[2], hc ^ 11'h5A, vc ^ 10'h33);
  endtask

  task automatic set_mready3(input logic v);
    @(posedge clk); #2 m_tready3 = v;
  endtask

  task automatic beat11(input logic [31:0] t, input logic u, input logic [10:0] hc, input logic [9:0] vc);
    int n;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) begin @(negedge clk); s_tvalid11 = 1'b0; end
    end
    @(negedge clk);
    s_tvalid11 = 1'b1; s_t11 = t; s_u11 = u; s_hc11 = hc; s_vc11 = vc;
    n = 0;
    while (!s_tready11 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check("dut11_s_tready_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  function automatic logic [31:0] rand_t();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[31] = 1'b1;                                    // negative
      1: r = 32'h0000_0000;                               // zero
      2: r = 32'h3A83_126F;                               // exactly MIN_T
      3: r = ($urandom_range(0, 1) != 0) ? 32'h7F80_0000 : 32'h7FC0_0001; // Inf / NaN
      4: case ($urandom_range(0, 2))                      // small pool, forces ties
           0: r = 32'h3F80_0000;
           1: r = 32'h4000_0000;
           default: r = 32'h3F00_0000;
         endcase
      5: r = 32'h3A83_1270;                               // just above MIN_T
      default: r = {1'b0, 8'($urandom_range(110, 140)), r[22:0]};
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input string name,
                              input logic [31:0] t0, t1, t2, input logic [2:0] u,
                              input logic [10:0] hc, input logic [9:0] vc,
                              input logic [31:0] et, input logic [1:0] eo, input logic eh);
    vec_t v;
    v.name = name; v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.u = u;
    v.hc = hc; v.vc = vc; v.et = et; v.eo = eo; v.eh = eh;
    return v;
  endfunction

  function automatic res_t exp_of(input logic [31:0] et, input logic [1:0] eo, input logic eh,
                                  input logic [10:0] hc, input logic [9:0] vc);
    return '{t: et, obj: {2'b00, eo}, hit: eh, hc: hc, vc: vc};
  endfunction

  // ---------------- directed test on dut3 ----------------
  task automatic directed3();
    vec_t vecs[$];
    logic [2:0][31:0] tt;
    int c_rel, c_end;

    vecs.push_back(mk("basic_min",  32'h40000000, 32'h3F800000, 32'h3F000000, 3'b000, 11'd5,   10'd7,   32'h3F000000, 2'd2, 1'b1));
    vecs.push_back(mk("all_undef",  32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b111, 11'd12,  10'd34,  32'h0,        2'd0, 1'b0));
    vecs.push_back(mk("neg_zero_lo",32'hBF800000, 32'h00000000, 32'h3A000000, 3'b000, 11'd100, 10'd200, 32'h0,        2'd0, 1'b0));
    vecs.push_back(mk("tie_low_idx",32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 11'd1,   10'd2,   32'h3F800000, 2'd0, 1'b1));
    vecs.push_back(mk("nan_skip",   32'h7FC00000, 32'h40000000, 32'h40400000, 3'b000, 11'd2047,10'd1023,32'h40000000, 2'd1, 1'b1));
    vecs.push_back(mk("threshold",  32'h3A83126F, 32'h3A831270, 32'h7F800000, 3'b000, 11'd640, 10'd480, 32'h3A831270, 2'd1, 1'b1));
    vecs.push_back(mk("undef_mask", 32'h40400000, 32'h3F000000, 32'h40000000, 3'b010, 11'd9,   10'd9,   32'h40000000, 2'd2, 1'b1));

    foreach (vecs[i]) begin
      q3.push_back(exp_of(vecs[i].et, vecs[i].eo, vecs[i].eh, vecs[i].hc, vecs[i].vc));
      ray3(vecs[i].t, vecs[i].u, vecs[i].hc, vecs[i].vc);
      @(negedge clk);
      s_tvalid3 = 1'b0;
      check({vecs[i].name, "_latency_tvalid"}, 64'(m_tvalid3), 64'd1);
    end

    // Backpressure: stall the first result for 10 cycles, then 4 rays back-to-back.
    set_mready3(1'b0);
    tt[0] = 32'h40000000; tt[1] = 32'h3F800000; tt[2] = 32'h3F000000;
    q3.push_back(exp_of(32'h3F000000, 2'd2, 1'b1, 11'd21, 10'd22));
    ray3(tt, 3'b000, 11'd21, 10'd22);
    c_rel = 0; c_end = 0;
    fork
      begin
        for (int r = 0; r < 4; r++) begin
          logic [2:0][31:0] tr;
          tr[0] = 32'h40800000 - 32'(r);
          tr[1] = 32'h3F800000 + 32'(r << 4);
          tr[2] = (r % 2 == 0) ? 32'h3F000000 : 32'hBF000000;
          q3.push_back(model(352'(tr), 11'(3'b000), 3, 11'(300 + r), 10'(400 + r)) );
          ray3(tr, 3'b000, 11'(300 + r), 10'(400 + r));
        end
        #1 c_end = cyc;
      end
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("stall_s_tready", 64'(s_tready3), 64'd0);
          check("stall_m_tvalid", 64'(m_tvalid3), 64'd1);
          check("stall_m_t_stable", 64'(m_t3), 64'h3F000000);
          check("stall_hcount_stable", 64'(m_hc3), 64'd21);
        end
        set_mready3(1'b1);
        c_rel = cyc;
      end
    join
    @(negedge clk);
    s_tvalid3 = 1'b0;
    check("back_to_back_cycles", 64'(c_end - c_rel), 64'd12);

    // Reset mid-ray: the partial accumulation must be discarded.
    repeat (3) @(negedge clk);
    check("pre_reset_queue_drained", 64'(q3.size()), 64'd0);
    beat3(32'h3E000000, 1'b0, 11'd77, 10'd88);
    beat3(32'h3E000000, 1'b0, 11'd77, 10'd88);
    @(negedge clk);
    s_tvalid3 = 1'b0;
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("mid_reset_tvalid", 64'(m_tvalid3), 64'd0);
    check("mid_reset_out", 64'({m_t3, m_obj3, m_hit3, m_hc3, m_vc3}), 64'd0);
    check("mid_reset_s_tready", 64'(s_tready3), 64'd1);
    tt[0] = 32'h40000000; tt[1] = 32'h3F800000; tt[2] = 32'h40400000;
    q3.push_back(exp_of(32'h3F800000, 2'd1, 1'b1, 11'd55, 10'd66));
    ray3(tt, 3'b000, 11'd55, 10'd66);
    @(negedge clk);
    s_tvalid3 = 1'b0;
    check("post_reset_latency_tvalid", 64'(m_tvalid3), 64'd1);
  endtask

  // ---------------- random test on dut11 ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2 m_tready11 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic random11();
    logic [10:0][31:0] t;
    logic [10:0]       u;
    logic [10:0]       hc;
    logic [9:0]        vc;
    for (int r = 0; r < 1000; r++) begin
      hc = 11'($urandom);
      vc = 10'($urandom);
      for (int i = 0; i < 11; i++) begin
        t[i] = rand_t();
        u[i] = ($urandom_range(0, 4) == 0);
      end
      q11.push_back(model(t, u, 11, hc, vc));
      for (int i = 0; i < 11; i++)
        beat11(t[i], u[i], (i == 0) ? hc : 11'($urandom), (i == 0) ? vc : 10'($urandom));
    end
    @(negedge clk);
    s_tvalid11 = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset_tvalid3", 64'(m_tvalid3), 64'd0);
    check("reset_out3", 64'({m_t3, m_obj3, m_hit3, m_hc3, m_vc3}), 64'd0);
    check("reset_tvalid11", 64'(m_tvalid11), 64'd0);
    check("reset_out11", 64'({m_t11, m_obj11, m_hit11, m_hc11, m_vc11}), 64'd0);
    rst3 = 1'b0;
    rst11 = 1'b0;
    fork
      directed3();
      random11();
    join
    n = 0;
    while ((q3.size() != 0 || q11.size() != 0) && n < 500) begin @(negedge clk); n++; end
    check("drain_q3", 64'(q3.size()), 64'd0);
    check("drain_q11", 64'(q11.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
